priority_interrupt_controller: RTL
==================================

PRIORITY_INTERRUPT_CONTROLLER -- requirements
Module: priority_interrupt_controller

Interface
REQ-001 Parameter DELAY_RISE, default 0, output rise delay in time units.
REQ-002 Parameter DELAY_FALL, default 0, output fall delay in time units.
REQ-003 Clk  input  1  sole clock, rising-edge active.
REQ-004 Clear  input  1  reset, asynchronous, active-high.
REQ-005 Req_bar  input  9  active-low request lines; bit 0 is line 1, bit 8 is line 9.
REQ-006 Mask  input  9  per-line mask, 1 = line ignored for arbitration; same bit order as Req_bar.
REQ-007 Ack  input  1  host acknowledge, active-high, four-phase handshake.
REQ-008 Int  output  1  interrupt to host, active-high.
REQ-009 Vector_bar  output  4  active-low binary code of granted line (1..9); 4'b1111 when nothing is granted.
REQ-010 Busy  output  1  high whenever state is not IDLE.

Function
REQ-011 Each line SHALL be sampled every Clk; a high-to-low change between consecutive samples SHALL set that line's pending bit.
REQ-012 Eligible set SHALL be pending AND NOT Mask; the highest-numbered eligible line (9 highest, 1 lowest) SHALL win.
REQ-013 States SHALL be IDLE, GRANT, SERVICE.
REQ-014 IDLE: if eligible set is non-empty at a Clk edge, go to GRANT on that edge and latch the winner's code into Vector_bar; otherwise stay in IDLE.
REQ-015 GRANT: Int = 1; Vector_bar holds the latched code; Ack = 1 sampled at a Clk edge moves to SERVICE.
REQ-016 SERVICE: Int = 0; Vector_bar holds; Ack = 0 sampled at a Clk edge clears the granted line's pending bit, drives Vector_bar to 4'b1111, and returns to IDLE.
REQ-017 Latency: falling request edge to Int high = 2 Clk edges (sample edge, then grant edge) when in IDLE.
REQ-018 Once granted, the grant SHALL NOT be revoked or re-prioritised by Mask changes or new higher-priority requests; these are arbitrated on the next IDLE.
REQ-019 Ack high in IDLE SHALL be ignored; a new grant SHALL NOT issue until Ack has been low, i.e. via the SERVICE exit.
REQ-020 Simultaneous set (new falling edge) and clear (service completion) on the same line SHALL leave pending set.
REQ-021 Masked pending bits SHALL be retained and become eligible when unmasked.
REQ-022 Request lines held low SHALL NOT re-set pending; only a fresh high-to-low change does.
REQ-023 Outputs SHALL be driven through DELAY_RISE/DELAY_FALL.

Reset
REQ-024 While Clear = 1: state = IDLE, pending = 0, request sample register = 9'b111111111, Int = 0, Busy = 0, Vector_bar = 4'b1111, regardless of Clk.
REQ-025 Reset asserted mid-GRANT or mid-SERVICE SHALL abandon the transaction with no pending bit retained.
REQ-026 A line already low at reset release SHALL count as a falling edge on the first Clk sample.

Structure
REQ-027 State encodings (IDLE = 0, GRANT = 1, SERVICE = 2), line count 9 and code width 4 SHALL live in a shared package.
REQ-028 Winner selection SHALL use the existing 10-line-to-4-line priority encoder sub-module ttl_74147, fed with the active-low inverse of the eligible set.
REQ-029 Edge detect, pending register, FSM and output latch SHALL live in this module; no other sub-module.

Verification
REQ-030 Clear pulse mid-GRANT with lines 3 and 7 pending -> Int = 0, Vector_bar = 4'b1111, Busy = 0 immediately; no grant after release until new edges.
REQ-031 Req_bar bit 5 (line 6) falls from all ones -> Int = 1, Vector_bar = ~4'b0110 two edges later; Ack 1 then 0 -> Int = 0, Vector_bar = 4'b1111, Busy = 0.
REQ-032 Lines 2, 4 and 9 fall on the same edge -> three transactions in order 9, 4, 2 (Vector_bar ~4'b1001, ~4'b0100, ~4'b0010).
REQ-033 Line 8 pending with Mask bit 7 = 1, line 1 pending -> line 1 granted (~4'b0001); after its service, Mask = 0 -> line 8 granted (~4'b1000).
REQ-034 During GRANT of line 3, line 9 falls -> Vector_bar stays ~4'b0011 through SERVICE; line 9 granted on the following IDLE.
REQ-035 Line 4 held low across its full service -> no second grant; release high then low again -> new grant ~4'b0100.

Source files
------------

// File: rtl/priority_interrupt_controller_pkg.sv
// ----------------------------------------------------------------------------
// priority_interrupt_controller_pkg
// Shared definitions for the nine-line priority interrupt controller:
//   - LINE_COUNT / CODE_WIDTH : number of request lines and vector code width
//   - pic_state_e             : handshake state encoding (IDLE/GRANT/SERVICE)
//   - VECTOR_IDLE             : Vector_bar value when nothing is granted
//   - code_to_onehot()        : maps a line code (1..9) to its pending-bit mask
// ----------------------------------------------------------------------------
package priority_interrupt_controller_pkg;

  localparam int LINE_COUNT = 9;
  localparam int CODE_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SERVICE = 2'd2
  } pic_state_e;

  localparam logic [CODE_WIDTH-1:0] VECTOR_IDLE = 4'b1111;

  // Line code 1..9 selects bit code-1; any other code yields an empty mask.
  function automatic logic [LINE_COUNT-1:0] code_to_onehot(input logic [CODE_WIDTH-1:0] code);
    logic [LINE_COUNT-1:0] onehot;
    onehot = {LINE_COUNT{1'b0}};
    for (int i = 0; i < LINE_COUNT; i++) begin
      if (code == CODE_WIDTH'(i + 1)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/priority_interrupt_controller_ttl_74147.sv
// ----------------------------------------------------------------------------
// ttl_74147
// 10-line to 4-line priority encoder (behavioural model of the classic part).
// Ports:
//   in_bar   [8:0] : active-low inputs, bit 0 = input 1 ... bit 8 = input 9
//   code_bar [3:0] : active-low binary code of the highest active input;
//                    4'b1111 (code 0) when no input is active
// Purely combinational.
// ----------------------------------------------------------------------------
module ttl_74147 (
  input  logic [8:0] in_bar,
  output logic [3:0] code_bar
);

  logic [3:0] code_s;

  // Ascending scan so the highest-numbered active input overwrites lower ones.
  always_comb begin
    code_s = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (in_bar[i] == 1'b0) begin
        code_s = 4'(i + 1);
      end else begin
        code_s = code_s;
      end
    end
    code_bar = ~code_s;
  end

endmodule

// File: rtl/priority_interrupt_controller.sv
// ----------------------------------------------------------------------------
// priority_interrupt_controller
// Nine-line edge-triggered interrupt controller with a four-phase host
// handshake. A high-to-low change on a request line sets its pending bit;
// the highest-numbered unmasked pending line is granted from IDLE, held
// through GRANT and SERVICE, and its pending bit cleared when Ack drops.
// Parameters:
//   DELAY_RISE / DELAY_FALL : output rise/fall delays for timing-annotated
//                             models; the synthesized outputs come straight
//                             from registers and carry no modelled delay.
// Ports:
//   Clk              : rising-edge clock
//   Clear            : asynchronous active-high reset
//   Req_bar    [8:0] : active-low request lines, bit 0 = line 1
//   Mask       [8:0] : 1 = line excluded from arbitration (pending retained)
//   Ack              : host acknowledge (high = taken, low = done)
//   Int              : interrupt to host, high in GRANT
//   Vector_bar [3:0] : active-low code of granted line, 4'b1111 when idle
//   Busy             : high whenever a transaction is in progress
// ----------------------------------------------------------------------------
module priority_interrupt_controller
  import priority_interrupt_controller_pkg::*;
#(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic [LINE_COUNT-1:0] Req_bar,
  input  logic [LINE_COUNT-1:0] Mask,
  input  logic                  Ack,
  output logic                  Int,
  output logic [CODE_WIDTH-1:0] Vector_bar,
  output logic                  Busy
);

  // Delays only matter to timing-annotated simulation models; negative
  // values are meaningless and leave an empty marker scope for inspection.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_negative_delay
  end

  pic_state_e            state_r;
  pic_state_e            state_s;
  logic [LINE_COUNT-1:0] sample_r;
  logic [LINE_COUNT-1:0] pending_r;
  logic [LINE_COUNT-1:0] pending_s;
  logic [LINE_COUNT-1:0] fall_s;
  logic [LINE_COUNT-1:0] eligible_s;
  logic [LINE_COUNT-1:0] clear_mask_s;
  logic [CODE_WIDTH-1:0] winner_bar_s;
  logic [CODE_WIDTH-1:0] vector_bar_r;
  logic [CODE_WIDTH-1:0] vector_bar_s;
  logic                  service_done_s;
  logic                  int_r;
  logic                  busy_r;

  // Falling edge = previous sample high, current input low. The sample
  // register resets to all ones so a line held low through reset release
  // registers as an edge on the first clock.
  assign fall_s     = sample_r & ~Req_bar;
  assign eligible_s = pending_r & ~Mask;

  ttl_74147 u_encoder (
    .in_bar   (~eligible_s),
    .code_bar (winner_bar_s)
  );

  // Next-state, vector latch value and service-completion strobe.
  always_comb begin
    state_s        = state_r;
    vector_bar_s   = vector_bar_r;
    service_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Ack is deliberately not looked at here.
        if (|eligible_s) begin
          state_s      = ST_GRANT;
          vector_bar_s = winner_bar_s;
        end else begin
          state_s      = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (Ack) begin
          state_s = ST_SERVICE;
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_SERVICE: begin
        if (!Ack) begin
          state_s        = ST_IDLE;
          vector_bar_s   = VECTOR_IDLE;
          service_done_s = 1'b1;
        end else begin
          state_s        = ST_SERVICE;
        end
      end
      default: begin
        state_s      = ST_IDLE;
        vector_bar_s = VECTOR_IDLE;
      end
    endcase
  end

  // Pending update: clear the serviced line, but a new edge on the same
  // clock wins so the request is not lost.
  always_comb begin
    if (service_done_s) begin
      clear_mask_s = code_to_onehot(~vector_bar_r);
    end else begin
      clear_mask_s = {LINE_COUNT{1'b0}};
    end
    pending_s = (pending_r & ~clear_mask_s) | fall_s;
  end

  // State, sampling, pending and registered output flops.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_r      <= ST_IDLE;
      sample_r     <= {LINE_COUNT{1'b1}};
      pending_r    <= {LINE_COUNT{1'b0}};
      vector_bar_r <= VECTOR_IDLE;
      int_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      sample_r     <= Req_bar;
      pending_r    <= pending_s;
      vector_bar_r <= vector_bar_s;
      int_r        <= (state_s == ST_GRANT);
      busy_r       <= (state_s != ST_IDLE);
    end
  end

  assign Int        = int_r;
  assign Vector_bar = vector_bar_r;
  assign Busy       = busy_r;

endmodule
